// File: rtl/tvs_monitor.sv
// Post-processor for the TVS sample stream: per-channel boxcar average, raw min/max,
// hysteretic alarms on one channel and a registered channel-indexed read port.
module tvs_monitor #(
  parameter int                 NUM_CH   = 4,
  parameter int                 CH_W     = 2,
  parameter int                 VALUE_W  = 16,
  parameter int                 AVG_LOG2 = 3,
  parameter int                 ALARM_CH = 0,
  parameter logic [VALUE_W-1:0] HYST     = VALUE_W'('h10)
) (
  input  logic               i_clk,
  input  logic               i_resetn,
  input  logic               i_en,
  input  logic               i_clear,
  input  logic               i_smp_valid,
  input  logic [CH_W-1:0]    i_smp_channel,
  input  logic [VALUE_W-1:0] i_smp_value,
  input  logic [VALUE_W-1:0] i_thr_high,
  input  logic [VALUE_W-1:0] i_thr_low,
  input  logic [CH_W-1:0]    i_rd_ch,
  output logic [VALUE_W-1:0] o_rd_avg,
  output logic [VALUE_W-1:0] o_rd_min,
  output logic [VALUE_W-1:0] o_rd_max,
  output logic               o_rd_avg_valid,
  output logic               o_avg_upd,
  output logic [CH_W-1:0]    o_avg_ch,
  output logic               o_alarm_high,
  output logic               o_alarm_low,
  output logic [7:0]         o_drop_cnt
);

  localparam int ACC_W = VALUE_W + AVG_LOG2;
  // With AVG_LOG2 = 0 the counter is a 1-bit constant zero, so every sample completes.
  localparam int CNT_W = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((1 << AVG_LOG2) - 1);

  logic [ACC_W-1:0]   r_acc [NUM_CH];
  logic [CNT_W-1:0]   r_cnt [NUM_CH];
  logic [VALUE_W-1:0] r_min [NUM_CH];
  logic [VALUE_W-1:0] r_max [NUM_CH];
  logic [VALUE_W-1:0] r_avg [NUM_CH];
  logic [NUM_CH-1:0]  r_vld;

  logic [VALUE_W-1:0] r_rd_avg, r_rd_min, r_rd_max;
  logic               r_rd_vld, r_avg_upd, r_alarm_high, r_alarm_low;
  logic [CH_W-1:0]    r_avg_ch;
  logic [7:0]         r_drop_cnt;

  logic               w_in_range, w_accept, w_drop, w_complete;
  logic [ACC_W-1:0]   w_acc_sel, w_sum;
  logic [CNT_W-1:0]   w_cnt_sel;
  logic [VALUE_W-1:0] w_avg_new;
  logic [VALUE_W-1:0] w_rd_avg, w_rd_min, w_rd_max;
  logic               w_rd_vld;
  logic [VALUE_W:0]   w_alarm_avg;
  logic               w_hi_set, w_hi_clr, w_lo_set, w_lo_clr;

  assign w_in_range = {1'b0, i_smp_channel} < (CH_W+1)'(NUM_CH);
  assign w_accept   = i_smp_valid & i_en & ~i_clear & w_in_range;
  assign w_drop     = i_smp_valid & i_en & ~i_clear & ~w_in_range;

  always_comb begin
    w_acc_sel = '0;
    w_cnt_sel = '0;
    w_rd_avg  = '0;
    w_rd_min  = '0;
    w_rd_max  = '0;
    w_rd_vld  = 1'b0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (i_smp_channel == CH_W'(i)) begin
        w_acc_sel = r_acc[i];
        w_cnt_sel = r_cnt[i];
      end
      if (i_rd_ch == CH_W'(i)) begin
        w_rd_avg = r_avg[i];
        w_rd_min = r_min[i];
        w_rd_max = r_max[i];
        w_rd_vld = r_vld[i];
      end
    end
    w_sum      = w_acc_sel + ACC_W'(i_smp_value);
    w_complete = w_accept && (w_cnt_sel == CNT_LAST);
    w_avg_new  = VALUE_W'(w_sum >> AVG_LOG2);
  end

  // One extra bit keeps threshold +/- hysteresis sums from wrapping.
  assign w_alarm_avg = {1'b0, r_avg[ALARM_CH]};
  assign w_hi_set    = w_alarm_avg >= {1'b0, i_thr_high};
  assign w_hi_clr    = (w_alarm_avg + {1'b0, HYST}) < {1'b0, i_thr_high};
  assign w_lo_set    = w_alarm_avg <= {1'b0, i_thr_low};
  assign w_lo_clr    = w_alarm_avg > ({1'b0, i_thr_low} + {1'b0, HYST});

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_acc[i] <= '0;
        r_cnt[i] <= '0;
        r_min[i] <= '1;
        r_max[i] <= '0;
        r_avg[i] <= '0;
      end
      r_vld <= '0;
    end else if (i_clear) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_acc[i] <= '0;
        r_cnt[i] <= '0;
        r_min[i] <= '1;
        r_max[i] <= '0;
      end
      r_vld <= '0;
    end else if (w_accept) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (i_smp_channel == CH_W'(i)) begin
          if (w_complete) begin
            r_acc[i] <= '0;
            r_cnt[i] <= '0;
            r_avg[i] <= w_avg_new;
            r_vld[i] <= 1'b1;
          end else begin
            r_acc[i] <= w_sum;
            r_cnt[i] <= r_cnt[i] + CNT_W'(1);
          end
          if (i_smp_value < r_min[i]) r_min[i] <= i_smp_value;
          if (i_smp_value > r_max[i]) r_max[i] <= i_smp_value;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      r_rd_avg     <= '0;
      r_rd_min     <= '0;
      r_rd_max     <= '0;
      r_rd_vld     <= 1'b0;
      r_avg_upd    <= 1'b0;
      r_avg_ch     <= '0;
      r_alarm_high <= 1'b0;
      r_alarm_low  <= 1'b0;
      r_drop_cnt   <= '0;
    end else begin
      r_rd_avg  <= w_rd_avg;
      r_rd_min  <= w_rd_min;
      r_rd_max  <= w_rd_max;
      r_rd_vld  <= w_rd_vld;
      r_avg_upd <= w_complete;
      if (w_complete) r_avg_ch <= i_smp_channel;
      if (w_drop && (r_drop_cnt != 8'hFF)) r_drop_cnt <= r_drop_cnt + 8'd1;
      if (w_hi_set)      r_alarm_high <= 1'b1;
      else if (w_hi_clr) r_alarm_high <= 1'b0;
      if (w_lo_set)      r_alarm_low <= 1'b1;
      else if (w_lo_clr) r_alarm_low <= 1'b0;
    end
  end

  assign o_rd_avg       = r_rd_avg;
  assign o_rd_min       = r_rd_min;
  assign o_rd_max       = r_rd_max;
  assign o_rd_avg_valid = r_rd_vld;
  assign o_avg_upd      = r_avg_upd;
  assign o_avg_ch       = r_avg_ch;
  assign o_alarm_high   = r_alarm_high;
  assign o_alarm_low    = r_alarm_low;
  assign o_drop_cnt     = r_drop_cnt;

endmodule

// File: tb/tb_tvs_monitor.sv
// Bench for tvs_monitor: directed scenarios plus random traffic, every cycle compared
// against an arithmetic model of per-channel averages, extremes, alarms and drops.
module tb_tvs_monitor;
  localparam int NUM_CH = 3;
  localparam int CH_W = 2;
  localparam int VALUE_W = 16;
  localparam int AVG_LOG2 = 3;
  localparam int NSMP = 8;
  localparam int ALARM_CH = 0;
  localparam int HYST_I = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn, en, clear, smp_valid;
  logic [CH_W-1:0] smp_ch, rd_ch;
  logic [VALUE_W-1:0] smp_val, thr_high, thr_low;
  logic [VALUE_W-1:0] rd_avg, rd_min, rd_max;
  logic rd_vld, avg_upd, alarm_high, alarm_low;
  logic [CH_W-1:0] avg_ch;
  logic [7:0] drop_cnt;

  tvs_monitor #(.NUM_CH(NUM_CH), .CH_W(CH_W), .VALUE_W(VALUE_W), .AVG_LOG2(AVG_LOG2),
                .ALARM_CH(ALARM_CH), .HYST(16'h0010)) dut (
    .i_clk(clk), .i_resetn(resetn), .i_en(en), .i_clear(clear),
    .i_smp_valid(smp_valid), .i_smp_channel(smp_ch), .i_smp_value(smp_val),
    .i_thr_high(thr_high), .i_thr_low(thr_low), .i_rd_ch(rd_ch),
    .o_rd_avg(rd_avg), .o_rd_min(rd_min), .o_rd_max(rd_max), .o_rd_avg_valid(rd_vld),
    .o_avg_upd(avg_upd), .o_avg_ch(avg_ch), .o_alarm_high(alarm_high),
    .o_alarm_low(alarm_low), .o_drop_cnt(drop_cnt));

  int n_chk = 0;
  int n_fail = 0;

  // Reference model: running sums and sample counts per channel.
  int m_sum [NUM_CH];
  int m_cnt [NUM_CH];
  int m_min [NUM_CH];
  int m_max [NUM_CH];
  int m_avg [NUM_CH];
  bit m_vld [NUM_CH];
  bit m_ah, m_al, m_upd;
  int m_avg_ch, m_drop;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_model(input bit full);
    for (int i = 0; i < NUM_CH; i++) begin
      m_sum[i] = 0;
      m_cnt[i] = 0;
      m_min[i] = 16'hFFFF;
      m_max[i] = 0;
      m_vld[i] = 0;
      if (full) m_avg[i] = 0;
    end
  endtask

  task automatic step();
    int e_avg, e_min, e_max, a, c;
    bit e_vld;
    @(posedge clk);
    if (!resetn) begin
      clear_model(1'b1);
      m_ah = 0; m_al = 0; m_upd = 0; m_avg_ch = 0; m_drop = 0;
      e_avg = 0; e_min = 0; e_max = 0; e_vld = 0;
    end else begin
      if (int'(rd_ch) < NUM_CH) begin
        e_avg = m_avg[rd_ch]; e_min = m_min[rd_ch]; e_max = m_max[rd_ch]; e_vld = m_vld[rd_ch];
      end else begin
        e_avg = 0; e_min = 0; e_max = 0; e_vld = 0;
      end
      a = m_avg[ALARM_CH];
      if (a >= int'(thr_high)) m_ah = 1;
      else if (a + HYST_I < int'(thr_high)) m_ah = 0;
      if (a <= int'(thr_low)) m_al = 1;
      else if (a > int'(thr_low) + HYST_I) m_al = 0;
      m_upd = 0;
      if (clear) clear_model(1'b0);
      else if (en && smp_valid) begin
        if (int'(smp_ch) < NUM_CH) begin
          c = smp_ch;
          m_sum[c] += int'(smp_val);
          m_cnt[c]++;
          if (int'(smp_val) < m_min[c]) m_min[c] = smp_val;
          if (int'(smp_val) > m_max[c]) m_max[c] = smp_val;
          if (m_cnt[c] == NSMP) begin
            m_avg[c] = m_sum[c] / NSMP;
            m_sum[c] = 0; m_cnt[c] = 0; m_vld[c] = 1;
            m_upd = 1; m_avg_ch = c;
          end
        end else if (m_drop < 255) m_drop++;
      end
    end
    #1;
    chk("rd_avg", rd_avg, e_avg);
    chk("rd_min", rd_min, e_min);
    chk("rd_max", rd_max, e_max);
    chk("rd_vld", rd_vld, e_vld);
    chk("avg_upd", avg_upd, m_upd);
    chk("avg_ch", avg_ch, m_avg_ch);
    chk("alarm_high", alarm_high, m_ah);
    chk("alarm_low", alarm_low, m_al);
    chk("drop_cnt", drop_cnt, m_drop);
  endtask

  task automatic smp(input int ch, input int val);
    smp_valid = 1; en = 1; clear = 0; smp_ch = CH_W'(ch); smp_val = VALUE_W'(val);
    step();
  endtask

  task automatic idle(input int n);
    smp_valid = 0; clear = 0;
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic fill(input int ch, input int val);
    for (int k = 0; k < NSMP; k++) smp(ch, val);
  endtask

  initial begin
    resetn = 0; en = 1; clear = 0; smp_valid = 0; smp_ch = 0; smp_val = 0; rd_ch = 0;
    thr_high = 16'h0800; thr_low = 16'h0100;
    step(); step();
    resetn = 1;
    for (int r = 0; r < 4; r++) begin
      rd_ch = CH_W'(r);
      idle(1);
    end

    // Ramp 100..107 on channel 1
    rd_ch = 1;
    for (int k = 0; k < NSMP; k++) smp(1, 100 + k);
    chk("ramp_upd", avg_upd, 1);
    chk("ramp_ch", avg_ch, 1);
    idle(1);
    chk("ramp_avg", rd_avg, 103);
    chk("ramp_min", rd_min, 100);
    chk("ramp_max", rd_max, 107);
    chk("ramp_vld", rd_vld, 1);

    // Interleaved channels 0 and 2
    for (int k = 0; k < NSMP; k++) begin
      smp(0, 16'h1000);
      smp(2, 16'h0200);
    end
    rd_ch = 2;
    idle(2);
    chk("il_avg2", rd_avg, 16'h0200);

    // High alarm hysteresis
    fill(0, 16'h0800); idle(2);
    chk("hi_set", alarm_high, 1);
    fill(0, 16'h07F5); idle(2);
    chk("hi_hold", alarm_high, 1);
    fill(0, 16'h07EF); idle(2);
    chk("hi_clr", alarm_high, 0);
    // Low alarm mirror
    fill(0, 16'h0100); idle(2);
    chk("lo_set", alarm_low, 1);
    fill(0, 16'h010A); idle(2);
    chk("lo_hold", alarm_low, 1);
    fill(0, 16'h0111); idle(2);
    chk("lo_clr", alarm_low, 0);

    // CLEAR on the 4th sample of channel 2
    rd_ch = 2;
    for (int k = 0; k < 3; k++) smp(2, 16'h0300 + k);
    smp_valid = 1; clear = 1; smp_ch = 2; smp_val = 16'h0303;
    step();
    idle(2);
    chk("clr_min", rd_min, 16'hFFFF);
    chk("clr_avg_kept", rd_avg, 16'h0200);
    for (int k = 0; k < NSMP - 1; k++) smp(2, 16'h0040);
    chk("clr_no_upd", avg_upd, 0);
    smp(2, 16'h0040);
    chk("clr_upd", avg_upd, 1);

    // EN low: nothing accepted or dropped
    en = 0; smp_valid = 1;
    for (int k = 0; k < 10; k++) begin
      smp_ch = CH_W'(k % 4); smp_val = VALUE_W'($urandom);
      step();
    end
    chk("en0_drop", drop_cnt, 0);

    // Drop saturation on out-of-range channel
    for (int k = 0; k < 300; k++) smp(3, $urandom_range(0, 65535));
    chk("drop_sat", drop_cnt, 255);

    // Random traffic
    thr_high = 16'h8000; thr_low = 16'h7000;
    for (int k = 0; k < 3000; k++) begin
      resetn    = ($urandom_range(0, 499) != 0);
      en        = ($urandom_range(0, 9) != 0);
      clear     = ($urandom_range(0, 49) == 0);
      smp_valid = ($urandom_range(0, 9) < 7);
      smp_ch    = CH_W'($urandom_range(0, 3));
      smp_val   = VALUE_W'($urandom);
      rd_ch     = CH_W'($urandom_range(0, 3));
      step();
    end
    resetn = 1;

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/tvs_monitor.md
# tvs_monitor

Parametrised post-processor for the PolarFire temperature/voltage sensor sample stream (VALID/CHANNEL/VALUE). Keeps per-channel boxcar averages and raw min/max. Raises hysteretic high/low alarms on one selected channel. Exposes everything through a registered channel-indexed read port for the slow-control register map. Sits between the TVS primitive wrapper and the ROC status registers.

## Interface
Parameters:
- NUM_CH, 4: number of sensor channels (1..16).
- CH_W, 2: channel index width; NUM_CH <= 2^CH_W.
- VALUE_W, 16: sample width, unsigned.
- AVG_LOG2, 3: average over 2^AVG_LOG2 samples (0..6; 0 = pass-through).
- ALARM_CH, 0: channel whose average drives the alarms.
- HYST, 16'h0010: alarm hysteresis in LSBs (VALUE_W wide).

Ports:
- CLK  in  1  single clock.
- RESETN  in  1  reset, synchronous, active-low.
- EN  in  1  sample acceptance enable; samples ignored while low.
- CLEAR  in  1  one-cycle pulse: clears accumulators, counters, min/max, valid bits.
- SMP_VALID  in  1  sample strobe, one cycle per sample.
- SMP_CHANNEL  in  CH_W  sample channel.
- SMP_VALUE  in  VALUE_W  sample value.
- THR_HIGH  in  VALUE_W  high alarm threshold, quasi-static.
- THR_LOW  in  VALUE_W  low alarm threshold, quasi-static.
- RD_CH  in  CH_W  read channel select.
- RD_AVG  out  VALUE_W  last average of RD_CH.
- RD_MIN  out  VALUE_W  raw minimum of RD_CH.
- RD_MAX  out  VALUE_W  raw maximum of RD_CH.
- RD_AVG_VALID  out  1  RD_CH has produced at least one average since reset/CLEAR.
- AVG_UPD  out  1  one-cycle pulse: a new average was written.
- AVG_CH  out  CH_W  channel of the AVG_UPD average.
- ALARM_HIGH  out  1  high alarm, hysteretic.
- ALARM_LOW  out  1  low alarm, hysteretic.
- DROP_CNT  out  8  saturating count of out-of-range-channel samples.

## Operation
- Accept condition: SMP_VALID & EN & ~CLEAR & (SMP_CHANNEL < NUM_CH). An accepted sample updates state for its channel ch at the same edge:
  - acc[ch] += SMP_VALUE. Width is VALUE_W+AVG_LOG2, so it cannot overflow.
  - cnt[ch] += 1 (AVG_LOG2 bits).
  - min[ch] = min(min[ch], SMP_VALUE); max[ch] = max(max[ch], SMP_VALUE).
- Average completion: when cnt[ch] == 2^AVG_LOG2-1 and a sample is accepted:
  - avg[ch] <= (acc[ch]+SMP_VALUE) >> AVG_LOG2 (truncation).
  - acc[ch] <= 0, cnt[ch] <= 0, vld[ch] <= 1.
  - AVG_UPD=1 and AVG_CH=ch in the following cycle.
- Out-of-range channel: sample dropped and DROP_CNT increments, provided EN=1 and CLEAR=0. DROP_CNT saturates at 255 and is cleared only by reset.
- CLEAR has priority over a simultaneous sample; that sample is discarded and not counted. CLEAR sets acc=0, cnt=0, min=all-ones, max=0, vld=0 for all channels. avg registers and alarm flags are not affected.
- Alarms are evaluated every cycle on a=avg[ALARM_CH] using VALUE_W+1-bit sums, so there is no wrap.
  - ALARM_HIGH: sets when a >= THR_HIGH; clears when a+HYST < THR_HIGH; otherwise holds.
  - ALARM_LOW: sets when a <= THR_LOW; clears when a > THR_LOW+HYST; otherwise holds.
  - Both flags may be high together if the thresholds overlap.
- Read port: RD_AVG/RD_MIN/RD_MAX/RD_AVG_VALID are registered from channel RD_CH. RD_CH >= NUM_CH reads all zeros.

## Timing
- Reset (RESETN low at an edge):
  - All outputs are 0.
  - Internal state: avg=0, acc=0, cnt=0, vld=0, min=all-ones, max=0, alarm flags 0.
- Sample at edge N:
  - acc/min/max/cnt updated at edge N.
  - AVG_UPD high in cycle N+1.
  - Alarm flags reflect the new average at edge N+1 (visible in cycle N+2).
- Read latency is 1 cycle. RD_CH changed before edge N gives data after edge N. State updated at edge N is visible on the read port after edge N+1.
- Back-to-back samples, any channel including the same one, are accepted every cycle with no stall.
- Reset mid-average discards the partial accumulation. Reset with SMP_VALID high discards the sample.

## Test plan
- Reset, then read channels 0..3 -> RD_MIN=16'hFFFF, RD_MAX=0, RD_AVG=0, RD_AVG_VALID=0 (RD_MIN reads 0 during the reset cycle).
- 8 samples on channel 1 with values 100..107, back-to-back -> one AVG_UPD pulse with AVG_CH=1 one cycle after the 8th sample; RD_AVG=103, RD_MIN=100, RD_MAX=107, RD_AVG_VALID=1.
- Interleaved samples: ch0 constant 16'h1000 and ch2 constant 16'h0200, 8 each -> two AVG_UPD pulses; ch0 avg 16'h1000, ch2 avg 16'h0200; other channels untouched.
- Alarm hysteresis, THR_HIGH=16'h0800, HYST=16'h10, ALARM_CH=0:
  - avg 16'h0800 -> ALARM_HIGH=1.
  - avg 16'h07F5 -> stays 1.
  - avg 16'h07EF -> clears.
  - Mirror check for ALARM_LOW with THR_LOW=16'h0100.
- CLEAR asserted together with the 4th sample of a channel -> sample discarded; that channel then needs 8 fresh samples for AVG_UPD; min/max reset; previous RD_AVG and alarms unchanged.
- With NUM_CH=3, 300 samples on channel 3 -> DROP_CNT=255 (saturated), no state change. Samples with EN=0 -> no update, DROP_CNT unchanged.
